// File: rtl/candy_sram_dp.sv
// candy_sram_dp: dual-port SRAM with byte-strobed writes, READ_LAT-cycle reads
// with a valid pulse, and an optional zeroing sweep after reset.
module candy_sram_dp #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [1<<ADDR_W];
  logic wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, rd_word;
  logic [NB-1:0] wr_strb;
  logic [READ_LAT-1:0] pv_q, pv_d;
  logic [READ_LAT-1:0][DATA_W-1:0] pd_q, pd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic valid_q, valid_d;
  assign ready = state_q == RUN;
  assign rd_en = ready & re;
  // the sweep borrows the write port while INIT
  assign wr_en   = ready ? we : 1'b1;
  assign wr_addr = ready ? waddr : cnt_q;
  assign wr_data = ready ? wdata : '0;
  assign wr_strb = ready ? wstrb : '1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == LAST ? RUN : INIT;
    end
  end
  // write-first: merge same-edge write bytes into the sampled word
  always_comb begin
    rd_word = mem[raddr];
    for (int i = 0; i < NB; i++)
      if (wr_en && wr_addr == raddr && wr_strb[i]) rd_word[8*i+:8] = wr_data[8*i+:8];
  end
  always_comb begin
    pv_d = pv_q;
    pd_d = pd_q;
    pv_d[0] = rd_en;
    pd_d[0] = rd_word;
    for (int i = 1; i < READ_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    valid_d = pv_q[READ_LAT-1];
    rdata_d = pv_q[READ_LAT-1] ? pd_q[READ_LAT-1] : rdata_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= CLEAR_ON_RESET ? INIT : RUN;
      cnt_q <= '0;
      pv_q <= '0;
      pd_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pv_q <= pv_d;
      pd_q <= pd_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  always_ff @(posedge clk)
    for (int i = 0; i < NB; i++)
      if (wr_en && wr_strb[i]) mem[wr_addr][8*i+:8] <= wr_data[8*i+:8];
  assign rdata = rdata_q;
  assign rdata_valid = valid_q;
endmodule

// File: tb/tb_candy_sram_dp.sv
// tb_candy_sram_dp: scoreboard bench driving READ_LAT=1 and READ_LAT=2 instances in lockstep.
module tb_candy_sram_dp;
  typedef struct {logic [31:0] d; int c;} exp_t;
  logic clk = 0, rst = 0, we = 0, re = 0;
  logic [3:0] waddr = 0, raddr = 0, wstrb = 0;
  logic [31:0] wdata = 0;
  logic ready0, ready1, ready2, valid0, valid1, valid2;
  logic [31:0] rdata0, rdata1, rdata2;
  exp_t exp_q[$];
  int cyc = 0, idx1 = 0, idx2 = 0, nassert = 0, nfail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  candy_sram_dp #(.DATA_W(32), .ADDR_W(4), .READ_LAT(1), .CLEAR_ON_RESET(0)) u0 (
    .clk(clk), .rst(rst), .ready(ready0), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .re(re), .raddr(raddr), .rdata(rdata0), .rdata_valid(valid0));
  candy_sram_dp #(.DATA_W(32), .ADDR_W(4), .READ_LAT(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .ready(ready1), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .re(re), .raddr(raddr), .rdata(rdata1), .rdata_valid(valid1));
  candy_sram_dp #(.DATA_W(32), .ADDR_W(4), .READ_LAT(2), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst(rst), .ready(ready2), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .re(re), .raddr(raddr), .rdata(rdata2), .rdata_valid(valid2));
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    nassert++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic mon(input int lat, input logic v, input logic [31:0] d, inout int idx);
    if (v) begin
      nassert++;
      if (idx >= exp_q.size()) begin
        nfail++;
        $display("FAIL rd_lat%0d: unexpected pulse data %h at cycle %0d expected none", lat, d, cyc);
      end else begin
        if (d !== exp_q[idx].d || cyc != exp_q[idx].c + lat) begin
          nfail++;
          $display("FAIL rd_lat%0d: got %h at cycle %0d expected %h at cycle %0d",
                   lat, d, cyc, exp_q[idx].d, exp_q[idx].c + lat);
        end
        idx++;
      end
    end
  endtask
  always @(negedge clk) mon(1, valid1, rdata1, idx1);
  always @(negedge clk) mon(2, valid2, rdata2, idx2);
  task automatic issue(input logic w, input logic r, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [3:0] ra, input logic [31:0] e);
    we = w; re = r; waddr = wa; wdata = wd; wstrb = ws; raddr = ra;
    if (r) exp_q.push_back('{e, cyc + 1});
    @(negedge clk);
    we = 0; re = 0;
  endtask
  task automatic sweep();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("ready_sweep_lat1", ready1, i == 16);
      check("ready_sweep_lat2", ready2, i == 16);
      if (i == 16) begin we = 0; re = 0; end
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready_clear", ready1, 0);
    check("rst_ready_noclear", ready0, 1);
    check("rst_rdata1", rdata1, 0);
    check("rst_valid1", valid1, 0);
    check("rst_rdata2", rdata2, 0);
    check("rst_valid2", valid2, 0);
    we = 1; waddr = 7; wdata = 32'hFFFFFFFF; wstrb = 4'hF; re = 1; raddr = 7;
    rst = 1;
    repeat (5) @(negedge clk);
    check("ready_mid_sweep", ready1, 0);
    rst = 0;
    @(negedge clk);
    rst = 1;
    sweep();
    check("ready_noclear_run", ready0, 1);
    for (int a = 0; a < 16; a++) issue(0, 1, 0, 0, 0, a[3:0], 0);
    issue(1, 0, 3, 32'hAABBCCDD, 4'hF, 0, 0);
    issue(1, 0, 3, 32'h11223344, 4'h5, 0, 0);
    issue(0, 1, 0, 0, 0, 3, 32'hAA22CC44);
    issue(1, 1, 5, 32'h12345678, 4'hF, 5, 32'h12345678);
    issue(1, 1, 3, 32'h99887766, 4'h8, 3, 32'h9922CC44);
    issue(1, 0, 0, 32'hA, 4'hF, 0, 0);
    issue(1, 0, 1, 32'hB, 4'hF, 0, 0);
    issue(1, 0, 2, 32'hC, 4'hF, 0, 0);
    issue(0, 1, 0, 0, 0, 0, 32'hA);
    issue(0, 1, 0, 0, 0, 1, 32'hB);
    issue(0, 1, 0, 0, 0, 2, 32'hC);
    issue(1, 1, 8, 32'h55, 4'hF, 0, 32'hA);
    issue(0, 1, 0, 0, 0, 8, 32'h55);
    issue(0, 1, 0, 0, 0, 1, 32'hB);
    issue(1, 0, 1, 32'hDEAD, 4'hF, 0, 0);
    issue(0, 1, 0, 0, 0, 1, 32'hDEAD);
    issue(1, 0, 2, 32'hFFFFFFFF, 4'h0, 0, 0);
    issue(0, 1, 0, 0, 0, 2, 32'hC);
    repeat (4) @(negedge clk);
    check("hold_rdata1", rdata1, 32'hC);
    check("hold_valid1", valid1, 0);
    check("hold_rdata2", rdata2, 32'hC);
    check("hold_valid2", valid2, 0);
    re = 1; raddr = 5;
    @(negedge clk);
    re = 0; rst = 0;
    #1;
    check("midrst_valid1", valid1, 0);
    check("midrst_valid2", valid2, 0);
    check("midrst_rdata1", rdata1, 0);
    check("midrst_rdata2", rdata2, 0);
    check("midrst_ready", ready1, 0);
    @(negedge clk);
    check("midrst_valid2_late", valid2, 0);
    rst = 1;
    sweep();
    issue(0, 1, 0, 0, 0, 5, 0);
    issue(0, 1, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    check("drained_lat1", idx1, exp_q.size());
    check("drained_lat2", idx2, exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/candy_sram_dp.md
# candy_sram_dp

Parametrised dual-port synchronous SRAM for the candy core: one write port with byte strobes, one independent read port with configurable read latency and a one-cycle `rdata_valid` pulse per read. An optional post-reset clear sweep zeroes the array before `ready` asserts. It serves as the data/instruction memory behind the core's load/store and fetch paths, and its word width and depth are set per instance.

## Interface
Parameters:
- `DATA_W`, 32: word width in bits; must be a multiple of 8.
- `ADDR_W`, 10: address width; depth = 2^ADDR_W words.
- `READ_LAT`, 1: read latency in cycles; legal values are 1 or 2.
- `CLEAR_ON_RESET`, 1: when 1, the array is zeroed by a sweep after reset; when 0, the array keeps its contents or initial file.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ready`  out  1  high when requests are accepted.
- `we`  in  1  write request.
- `waddr`  in  ADDR_W  write word address.
- `wdata`  in  DATA_W  write data.
- `wstrb`  in  DATA_W/8  byte enables; bit i covers `wdata[8i+7:8i]`.
- `re`  in  1  read request.
- `raddr`  in  ADDR_W  read word address.
- `rdata`  out  DATA_W  read data; holds its value between reads.
- `rdata_valid`  out  1  one-cycle pulse when `rdata` carries a new result.

## Operation
- States: `INIT` (sweep in progress) and `RUN`. On reset, the block enters `INIT` if `CLEAR_ON_RESET=1`, otherwise `RUN`.
- `INIT` behaviour:
  - An internal counter starts at 0. Each edge writes zero to `mem[cnt]` and increments the counter.
  - The edge that writes address 2^ADDR_W-1 moves the block to `RUN`.
  - `we` and `re` are ignored.
- `ready` = (state == `RUN`). A request is accepted on an edge where `ready` is 1 and `we` or `re` is 1.
- Write: for each byte i with `wstrb[i]=1`, `mem[waddr]` byte i takes the matching `wdata` byte. Bytes whose strobe is 0 are unchanged. `we=1` with `wstrb=0` changes nothing.
- Read: the array is sampled at the accepting edge. The result goes to `rdata` after `READ_LAT` edges, together with the `rdata_valid` pulse.
- Simultaneous read and write to the same address: write-first. The read returns the merged word (old bytes where the strobe is 0, new bytes where it is 1).
- Simultaneous read and write to different addresses: both complete independently.
- With `READ_LAT=2`, a write on the cycle after a read's acceptance is not forwarded; the read returns the pre-write data.
- A read can be accepted every cycle. Reads are never dropped or reordered.
- Addresses are always in range (2^ADDR_W words); there is no wrap logic.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `rdata` = 0 and `rdata_valid` = 0.
  - `ready` = 0 if `CLEAR_ON_RESET=1`, otherwise 1.
  - The sweep counter is 0 and the read pipeline is empty.
  - Array contents are not reset asynchronously.
- With `CLEAR_ON_RESET=1`, `ready` rises after exactly 2^ADDR_W rising edges following `rst` deassertion.
- Read issued at edge N: `rdata` and `rdata_valid`=1 are visible after edge N+`READ_LAT` and remain so until edge N+`READ_LAT`+1. `rdata_valid` then falls unless another read follows.
- Write issued at edge N is visible to a read accepted at edge N (via forwarding) and to any later read.
- Reset asserted mid-sweep: the sweep restarts at address 0 after deassertion.
- Reset asserted with reads in flight: pending results are discarded and no `rdata_valid` pulse appears for them.

## Test plan
- Reset sweep, `ADDR_W=4`, `CLEAR_ON_RESET=1`: deassert `rst` → `ready`=0 for 16 edges then 1; reading addresses 0..15 returns 0x00000000.
- Byte strobes: write 0xAABBCCDD to address 3 with `wstrb=1111`, then write 0x11223344 with `wstrb=0101` → read of address 3 returns 0xAA22CC44 with a single `rdata_valid` pulse 1 cycle later (`READ_LAT=1`).
- Same-cycle collision: `mem[5]`=0x0, then `we`,`re` to 5 with `wdata`=0x12345678 and `wstrb=1111` → `rdata`=0x12345678 after 1 edge.
- Back-to-back reads, `READ_LAT=2`: reads of addresses 0,1,2 on consecutive edges (contents 0xA,0xB,0xC) → `rdata` shows 0xA, 0xB, 0xC on edges 2, 3, 4 with `rdata_valid` held high for 3 cycles.
- Requests during `INIT`: `we` to address 7 with 0xFFFFFFFF while `ready`=0 → after the sweep, address 7 reads 0x0.
- Reset mid-operation: assert `rst` between a read's acceptance and its result (`READ_LAT=2`) → no `rdata_valid` pulse appears; `rdata`=0 and the sweep restarts at address 0.
